// File: rtl/fifo_1to16.sv
// fifo_1to16: packs a byte stream into 16-lane words and buffers them in a DEPTH-word SRAM
// Ports:
//   clock, reset                       rising-edge clock, synchronous active-high reset
//   valid_i, ready_o, last_i, data_i   byte input stream, lane 0 is the first byte of a word
//   valid_o, ready_i, last_o, data_o   word output stream, first-word fall-through
//   count_o                            number of valid lanes in data_o, 1..16
module fifo_1to16 #(
   parameter int WIDTH = 8,
   parameter int ABITS = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic                  last_i,
   input  logic [WIDTH-1:0]      data_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  last_o,
   output logic [4:0]            count_o,
   output logic [16*WIDTH-1:0]   data_o
);
   localparam int DEPTH = 1 << ABITS;
   localparam logic [ABITS:0] FULL = (ABITS+1)'(DEPTH);
   localparam logic [ABITS:0] ONE = (ABITS+1)'(1);
   logic [16*WIDTH+5:0] mem [DEPTH];
   logic [15:0][WIDTH-1:0] pack, word;
   logic [3:0] bidx, bidx_n;
   logic [4:0] cnt, hold_cnt;
   logic hold, hold_last, lst, accept, fin, req, wr, pop, cons, hold_n;
   logic [ABITS:0] waddr, raddr, level, occ, occ_c, occ_n;
   // Occupancy includes the output register, so no more than DEPTH words are held in total.
   // A last byte that arrives with no free slot parks its finished word in the pack register
   // (hold) and stalls input until a slot frees; ready_o stays high mid-word while full.
   always_comb begin
      accept = valid_i && ready_o;
      fin = accept && (bidx == 4'd15 || last_i);
      req = fin || hold;
      word = pack;
      word[bidx] = hold ? pack[bidx] : data_i;
      cnt = hold ? hold_cnt : {1'b0, bidx} + 5'd1;
      lst = hold ? hold_last : last_i;
      level = waddr - raddr;
      cons = valid_o && ready_i;
      occ = level + {{ABITS{1'b0}}, valid_o};
      occ_c = occ - {{ABITS{1'b0}}, cons};
      wr = req && occ_c < FULL;
      pop = level != '0 && (!valid_o || ready_i);
      hold_n = req && !wr;
      bidx_n = req ? 4'd0 : accept ? bidx + 4'd1 : bidx;
      occ_n = occ_c + {{ABITS{1'b0}}, wr};
   end
   always_ff @(posedge clock)
      if (wr && !reset) mem[waddr[ABITS-1:0]] <= {lst, cnt, word};
   always_ff @(posedge clock) begin
      if (reset) begin
         pack <= '0;
         bidx <= '0;
         hold <= 1'b0;
         hold_cnt <= '0;
         hold_last <= 1'b0;
         waddr <= '0;
         raddr <= '0;
         ready_o <= 1'b0;
         valid_o <= 1'b0;
         last_o <= 1'b0;
         count_o <= '0;
         data_o <= '0;
      end else begin
         if (req) begin
            pack <= wr ? '0 : word;
            hold <= !wr;
            hold_cnt <= cnt;
            hold_last <= lst;
         end else if (accept) pack <= word;
         bidx <= bidx_n;
         if (wr) waddr <= waddr + ONE;
         ready_o <= !hold_n && (occ_n < FULL || bidx_n != 4'd15);
         if (pop) begin
            {last_o, count_o, data_o} <= mem[raddr[ABITS-1:0]];
            valid_o <= 1'b1;
            raddr <= raddr + ONE;
         end else if (ready_i) valid_o <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fifo_1to16.sv
// tb_fifo_1to16: directed vectors, fill/stall corners, reset mid-packet and a random scoreboard run
module tb_fifo_1to16;
   logic clock = 1'b0, reset = 1'b1, valid_i = 1'b0, last_i = 1'b0, ready_i = 1'b0;
   logic [7:0] data_i = '0;
   logic ready_o, valid_o, last_o;
   logic [4:0] count_o;
   logic [127:0] data_o;
   typedef struct packed {logic [127:0] d; logic [4:0] c; logic l;} word_t;
   typedef struct {int n; logic [7:0] base; logic l; logic [127:0] d; logic [4:0] c; logic el;} vec_t;
   word_t outq[$], expq[$];
   vec_t v[8];
   logic [127:0] cur_w = '0, e;
   int cur_n = 0, acc = 0, passed = 0, total = 0, ob, eb, a0, bad;

   fifo_1to16 dut (.clock(clock), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
      .last_i(last_i), .data_i(data_i), .valid_o(valid_o), .ready_i(ready_i),
      .last_o(last_o), .count_o(count_o), .data_o(data_o));

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (reset) begin
         cur_w = '0;
         cur_n = 0;
      end else begin
         if (valid_o && ready_i) outq.push_back({data_o, count_o, last_o});
         if (valid_i && ready_o) begin
            acc++;
            cur_w[cur_n*8 +: 8] = data_i;
            cur_n++;
            if (cur_n == 16 || last_i) begin
               expq.push_back({cur_w, 5'(cur_n), last_i});
               cur_w = '0;
               cur_n = 0;
            end
         end
      end
   end

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic cycles(int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic put(logic [7:0] d, logic l);
      bit a = 1'b0;
      valid_i = 1'b1;
      data_i = d;
      last_i = l;
      for (int i = 0; i < 2000 && !a; i++) begin
         @(negedge clock);
         a = ready_o;
         @(posedge clock);
         #1;
      end
      if (!a) begin
         total++;
         $display("FAIL put: byte %h not accepted within 2000 cycles", d);
      end
   endtask

   task automatic idle();
      valid_i = 1'b0;
      last_i = 1'b0;
   endtask

   task automatic wait_out(int n, int budget);
      for (int i = 0; i < budget && outq.size() < n; i++) @(negedge clock);
      cycles(3);
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
      cycles(1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      v[0] = '{16, 8'h00, 1'b0, 128'h0f0e0d0c0b0a09080706050403020100, 5'd16, 1'b0};
      v[1] = '{16, 8'h10, 1'b1, 128'h1f1e1d1c1b1a19181716151413121110, 5'd16, 1'b1};
      v[2] = '{5, 8'ha0, 1'b1, 128'ha4a3a2a1a0, 5'd5, 1'b1};
      v[3] = '{1, 8'h5a, 1'b1, 128'h5a, 5'd1, 1'b1};
      v[4] = '{15, 8'h30, 1'b1, 128'h3e3d3c3b3a39383736353433323130, 5'd15, 1'b1};
      v[5] = '{16, 8'hf0, 1'b0, 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0, 5'd16, 1'b0};
      v[6] = '{2, 8'hc0, 1'b1, 128'hc1c0, 5'd2, 1'b1};
      v[7] = '{16, 8'h40, 1'b1, 128'h4f4e4d4c4b4a49484746454443424140, 5'd16, 1'b1};
      ready_i = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset ready_o", 128'(ready_o), 0);
      chk("reset valid_o", 128'(valid_o), 0);
      chk("reset last_o", 128'(last_o), 0);
      chk("reset count_o", 128'(count_o), 0);
      chk("reset data_o", data_o, 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      cycles(1);
      @(negedge clock);
      chk("ready after reset", 128'(ready_o), 1);
      @(posedge clock);
      #1;
      for (int k = 0; k < 8; k++) begin
         ob = outq.size();
         for (int i = 0; i < v[k].n; i++) put(v[k].base + 8'(i), v[k].l && i == v[k].n - 1);
         idle();
         repeat (3) @(posedge clock);
         @(negedge clock);
         chk($sformatf("v%0d latency", k), 128'(outq.size() > ob), 1);
         cycles(4);
         chk($sformatf("v%0d words", k), 128'(outq.size() - ob), 1);
         if (outq.size() > ob) begin
            chk($sformatf("v%0d data", k), outq[ob].d, v[k].d);
            chk($sformatf("v%0d count", k), 128'(outq[ob].c), 128'(v[k].c));
            chk($sformatf("v%0d last", k), 128'(outq[ob].l), 128'(v[k].el));
         end
      end
      do_reset();
      ready_i = 1'b0;
      a0 = acc;
      for (int i = 0; i < 400; i++) begin
         valid_i = 1'b1;
         data_i = 8'(acc - a0);
         if (i == 20 || i == 30) begin
            chk($sformatf("hold data @%0d", i), data_o, 128'h0f0e0d0c0b0a09080706050403020100);
            chk($sformatf("hold valid/last/count @%0d", i), 128'({valid_o, last_o, count_o}), 128'({1'b1, 1'b0, 5'd16}));
         end
         @(posedge clock);
         #1;
      end
      idle();
      chk("fill accepted bytes", 128'(acc - a0), 271);
      chk("fill ready_o low", 128'(ready_o), 0);
      ob = outq.size();
      ready_i = 1'b1;
      wait_out(ob + 16, 80);
      chk("fill drained words", 128'(outq.size() - ob), 16);
      for (int k = 0; k < 16 && ob + k < outq.size(); k++) begin
         for (int j = 0; j < 16; j++) e[j*8 +: 8] = 8'(16*k + j);
         chk($sformatf("fill word%0d data", k), outq[ob+k].d, e);
         chk($sformatf("fill word%0d last/count", k), 128'({outq[ob+k].l, outq[ob+k].c}), 128'({1'b0, 5'd16}));
      end
      ob = outq.size();
      put(8'h0f, 1'b1);
      idle();
      wait_out(ob + 1, 10);
      chk("fill tail words", 128'(outq.size() - ob), 1);
      if (outq.size() > ob) begin
         chk("fill tail data", outq[ob].d, 128'h0f0e0d0c0b0a09080706050403020100);
         chk("fill tail last/count", 128'({outq[ob].l, outq[ob].c}), 128'({1'b1, 5'd16}));
      end
      do_reset();
      ready_i = 1'b0;
      a0 = acc;
      for (int i = 0; i < 256; i++) put(8'(i), 1'b0);
      put(8'h00, 1'b0);
      put(8'h01, 1'b0);
      put(8'h02, 1'b1);
      idle();
      cycles(2);
      chk("full last ready_o low", 128'(ready_o), 0);
      chk("full last accepted", 128'(acc - a0), 259);
      ob = outq.size();
      ready_i = 1'b1;
      wait_out(ob + 17, 80);
      chk("full last words", 128'(outq.size() - ob), 17);
      if (outq.size() >= ob + 17) begin
         chk("full word15 data", outq[ob+15].d, 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0);
         chk("full word16 data", outq[ob+16].d, 128'h020100);
         chk("full word16 last/count", 128'({outq[ob+16].l, outq[ob+16].c}), 128'({1'b1, 5'd3}));
      end
      do_reset();
      ready_i = 1'b1;
      ob = outq.size();
      for (int i = 0; i < 7; i++) put(8'h70 + 8'(i), 1'b0);
      idle();
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk("midreset valid_o", 128'(valid_o), 0);
      chk("midreset ready_o", 128'(ready_o), 0);
      reset = 1'b0;
      cycles(1);
      for (int i = 0; i < 16; i++) put(8'h10 + 8'(i), 1'b0);
      idle();
      wait_out(ob + 1, 10);
      chk("midreset words", 128'(outq.size() - ob), 1);
      if (outq.size() > ob) begin
         chk("midreset data", outq[ob].d, 128'h1f1e1d1c1b1a19181716151413121110);
         chk("midreset last/count", 128'({outq[ob].l, outq[ob].c}), 128'({1'b0, 5'd16}));
      end
      do_reset();
      ob = outq.size();
      eb = expq.size();
      a0 = acc;
      for (int i = 0; i < 30000 && acc - a0 < 10000; i++) begin
         valid_i = $urandom_range(3) != 0;
         data_i = 8'($urandom);
         last_i = $urandom_range(19) == 0;
         ready_i = $urandom_range(3) != 0;
         @(posedge clock);
         #1;
      end
      ready_i = 1'b1;
      put(8'h99, 1'b1);
      idle();
      wait_out(ob + expq.size() - eb, 100);
      chk("random word count", 128'(outq.size() - ob), 128'(expq.size() - eb));
      bad = 0;
      for (int k = 0; k < expq.size() - eb && ob + k < outq.size(); k++)
         if (outq[ob+k] != expq[eb+k]) bad++;
      chk("random mismatched words", 128'(bad), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
